// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
// Contents: op codes, FSM state codes, iteration count, HI/LO write payload.
package hilo_muldiv_pkg;

   localparam int unsigned MD_ITER = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // HI/LO write payload as seen by the register file
   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_wr_t;

   function automatic logic md_is_mul(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic md_is_signed(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/hilo_muldiv_md_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of product/quotient/remainder.
// Ports:
//   val_i  - value to condition
//   neg_i  - 1: output is -val_i, 0: output is val_i
//   val_o  - conditioned value (combinational)
module md_sign_fix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit producing the HI/LO register write stream.
// One accepted op computes over 32 cycles (radix-2 shift-add multiply or
// restoring divide), then issues a single-cycle write.
// Optional build macro: HILO_MULDIV_FAST_MUL_EN -- multiplies use a
// single-cycle product and skip the iterative phase.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   start_i, op_i      - request and operation (MULT/MULTU/DIV/DIVU)
//   src_a_i, src_b_i   - multiplicand/dividend, multiplier/divisor
//   cancel_i           - flush; aborts the in-flight op and suppresses we
//   stall_o            - combinational busy indication to the pipeline
//   we, w_hi_o, w_lo_o - registered HI/LO write strobe and data
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] src_a_i,
   input  logic [DATA_W-1:0] src_b_i,
   input  logic              cancel_i,
   output logic              stall_o,
   output logic              we,
   output logic [DATA_W-1:0] w_hi_o,
   output logic [DATA_W-1:0] w_lo_o
);

   localparam int unsigned ACC_W = 2 * DATA_W;

   md_state_e         state;
   md_op_e            op_q;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;      // mul: {partial hi, multiplier/low product}; div: {rem, quot}
   logic [DATA_W-1:0] opnd;     // multiplicand or divisor magnitude
   logic              res_neg;
   logic              rem_neg;

   // Input decode and operand magnitudes
   md_op_e            op_in;
   logic              in_signed;
   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] abs_a;
   logic [DATA_W-1:0] abs_b;
   logic              accept;
   logic              div_zero;

   assign op_in     = md_op_e'(op_i);
   assign in_signed = md_is_signed(op_in);
   assign a_neg     = in_signed & src_a_i[DATA_W-1];
   assign b_neg     = in_signed & src_b_i[DATA_W-1];
   assign accept    = (state == MD_IDLE) & start_i & ~cancel_i;
   assign div_zero  = ~md_is_mul(op_in) & (src_b_i == '0);
   assign stall_o   = (state != MD_IDLE) | accept;

   md_sign_fix #(.W(DATA_W)) u_abs_a (.val_i(src_a_i), .neg_i(a_neg), .val_o(abs_a));
   md_sign_fix #(.W(DATA_W)) u_abs_b (.val_i(src_b_i), .neg_i(b_neg), .val_o(abs_b));

   // Shift-add step: add multiplicand into the high half if the current
   // multiplier bit is set, then shift the whole accumulator right.
   logic [DATA_W:0]  mul_sum;
   logic [ACC_W-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[ACC_W-1:DATA_W]} + ({1'b0, opnd} & {(DATA_W+1){acc[0]}});
   assign mul_next = {mul_sum, acc[DATA_W-1:1]};

   // Restoring divide step: shift next dividend bit into the remainder and
   // keep the subtraction only when it does not go negative.
   logic [DATA_W:0]  div_shift;
   logic [DATA_W:0]  div_trial;
   logic [ACC_W-1:0] div_next;

   assign div_shift = {acc[ACC_W-1:DATA_W], acc[DATA_W-1]};
   assign div_trial = div_shift - {1'b0, opnd};
   assign div_next  = div_trial[DATA_W]
                    ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                    : {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

   // Result sign restore; quotient reuses the wide negator via zero-extension
   logic [ACC_W-1:0]  res_raw;
   logic [ACC_W-1:0]  res_fix;
   logic [DATA_W-1:0] rem_fix;
   md_wr_t            wr_c;

   assign res_raw = md_is_mul(op_q) ? acc : {{DATA_W{1'b0}}, acc[DATA_W-1:0]};

   md_sign_fix #(.W(ACC_W))  u_fix_res (.val_i(res_raw), .neg_i(res_neg), .val_o(res_fix));
   md_sign_fix #(.W(DATA_W)) u_fix_rem (.val_i(acc[ACC_W-1:DATA_W]), .neg_i(rem_neg), .val_o(rem_fix));

   always_comb begin
      wr_c.hi = rem_fix;
      wr_c.lo = res_fix[DATA_W-1:0];
      if (md_is_mul(op_q)) begin
         wr_c.hi = res_fix[ACC_W-1:DATA_W];
      end
   end

   // Control FSM with registered write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= MD_IDLE;
         op_q    <= MD_MULT;
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         res_neg <= 1'b0;
         rem_neg <= 1'b0;
         we      <= 1'b0;
         w_hi_o  <= '0;
         w_lo_o  <= '0;
      end else begin
         we <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (accept) begin
                  op_q    <= op_in;
                  cnt     <= '0;
                  res_neg <= a_neg ^ b_neg;
                  rem_neg <= a_neg & ~md_is_mul(op_in);
                  if (div_zero) begin
                     // Raw dividend to HI, all-ones to LO, no sign restore
                     acc     <= {src_a_i, {DATA_W{1'b1}}};
                     opnd    <= abs_b;
                     res_neg <= 1'b0;
                     rem_neg <= 1'b0;
                     state   <= MD_DONE;
                  end else if (md_is_mul(op_in)) begin
`ifdef HILO_MULDIV_FAST_MUL_EN
                     acc   <= ACC_W'(abs_a) * ACC_W'(abs_b);
                     opnd  <= abs_a;
                     state <= MD_DONE;
`else
                     acc   <= {{DATA_W{1'b0}}, abs_b};
                     opnd  <= abs_a;
                     state <= MD_CALC;
`endif
                  end else begin
                     acc   <= {{DATA_W{1'b0}}, abs_a};
                     opnd  <= abs_b;
                     state <= MD_CALC;
                  end
               end
            end

            MD_CALC: begin
               if (cancel_i) begin
                  state <= MD_IDLE;
               end else begin
                  acc <= md_is_mul(op_q) ? mul_next : div_next;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(MD_ITER - 1)) begin
                     state <= MD_DONE;
                  end
               end
            end

            MD_DONE: begin
               state <= MD_IDLE;
               if (!cancel_i) begin
                  we     <= 1'b1;
                  w_hi_o <= wr_c.hi;
                  w_lo_o <= wr_c.lo;
               end
            end

            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv: arithmetic results, latency,
// divide-by-zero, signed overflow, cancel and asynchronous reset behaviour.
module tb_hilo_muldiv;
   import hilo_muldiv_pkg::*;

`ifdef HILO_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] src_a_i;
   logic [31:0] src_b_i;
   logic        cancel_i;
   logic        stall_o;
   logic        we;
   logic [31:0] w_hi_o;
   logic [31:0] w_lo_o;

   int n_tests = 0;
   int n_fail  = 0;

   hilo_muldiv dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .op_i     (op_i),
      .src_a_i  (src_a_i),
      .src_b_i  (src_b_i),
      .cancel_i (cancel_i),
      .stall_o  (stall_o),
      .we       (we),
      .w_hi_o   (w_hi_o),
      .w_lo_o   (w_lo_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op, wait for its write (bounded), check latency and data.
   // poke: hold start_i with junk operands for a few cycles mid-op.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat_exp, input logic [31:0] hi_exp,
                         input logic [31:0] lo_exp, input bit poke, input bit chk_pulse);
      int lat;
      @(negedge clk);
      start_i = 1'b1;
      op_i    = op;
      src_a_i = a;
      src_b_i = b;
      #1 check({tag, " stall_start"}, 64'(stall_o), 64'd1);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      op_i    = MD_MULTU;
      src_a_i = 32'h0000_0003;
      src_b_i = 32'h0000_0003;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (poke) start_i = (lat >= 5 && lat < 8);
         if (lat == 10) check({tag, " stall_mid"}, 64'(stall_o), 64'd1);
      end while (!we && lat < 100);
      start_i = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'(lat_exp));
      check({tag, " hi"}, 64'(w_hi_o), 64'(hi_exp));
      check({tag, " lo"}, 64'(w_lo_o), 64'(lo_exp));
      check({tag, " stall_wr"}, 64'(stall_o), 64'd0);
      if (chk_pulse) begin
         @(posedge clk);
         #1 check({tag, " we_pulse"}, 64'(we), 64'd0);
         check({tag, " hi_hold"}, 64'(w_hi_o), 64'(hi_exp));
      end
   endtask

   // Count write strobes over a window; used after cancelled requests.
   task automatic count_we(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (we) n++;
      end
   endtask

   int nwe;

   initial begin
      rst      = 1'b0;
      start_i  = 1'b0;
      cancel_i = 1'b0;
      op_i     = '0;
      src_a_i  = '0;
      src_b_i  = '0;
      #3;
      check("reset stall", 64'(stall_o), 64'd0);
      check("reset we",    64'(we),      64'd0);
      check("reset hi",    64'(w_hi_o),  64'd0);
      check("reset lo",    64'(w_lo_o),  64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, MUL_LAT, 32'h1, 32'hFFFF_FFFE, 0, 1);
      // next two are back-to-back: second start lands in the write cycle
      run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'h5, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0);
      run_op("divu", MD_DIVU, 32'd100, 32'd7, DIV_LAT, 32'h2, 32'hE, 1, 1);
      run_op("div_na", MD_DIV, 32'hFFFF_FFF9, 32'h2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1);
      run_op("div_nb", MD_DIV, 32'h7, 32'hFFFF_FFFE, DIV_LAT, 32'h1, 32'hFFFF_FFFD, 0, 1);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 0, 1);
      run_op("divu_z", MD_DIVU, 32'h1234, 32'h0, 1, 32'h1234, 32'hFFFF_FFFF, 0, 1);
      run_op("div_z", MD_DIV, 32'hFFFF_FFFB, 32'h0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 1);
      run_op("mult_mm", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'h0, 32'h1, 0, 1);
      run_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0, 0, 1);

      // Cancel mid-divide
      @(negedge clk);
      start_i = 1'b1;
      op_i    = MD_DIV;
      src_a_i = 32'hFFFF_FF9C;
      src_b_i = 32'h3;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      cancel_i = 1'b1;
      @(posedge clk);
      #1 cancel_i = 1'b0;
      check("cancel stall", 64'(stall_o), 64'd0);
      count_we(40, nwe);
      check("cancel no_we", 64'(nwe), 64'd0);
      check("cancel hi_hold", 64'(w_hi_o), 64'h4000_0000);
      run_op("after_cancel", MD_DIVU, 32'hFFFF_FFFF, 32'h1, DIV_LAT, 32'h0, 32'hFFFF_FFFF, 0, 1);

      // Cancel together with start in IDLE: nothing accepted
      @(negedge clk);
      start_i  = 1'b1;
      cancel_i = 1'b1;
      op_i     = MD_DIVU;
      src_a_i  = 32'h77;
      src_b_i  = 32'h0;
      #1 check("cancel_start stall", 64'(stall_o), 64'd0);
      @(posedge clk);
      #1;
      start_i  = 1'b0;
      cancel_i = 1'b0;
      count_we(5, nwe);
      check("cancel_start no_we", 64'(nwe), 64'd0);

      // Cancel coinciding with DONE (divide-by-zero goes straight there)
      @(negedge clk);
      start_i = 1'b1;
      op_i    = MD_DIVU;
      src_a_i = 32'h55;
      src_b_i = 32'h0;
      @(posedge clk);
      #1;
      start_i  = 1'b0;
      cancel_i = 1'b1;
      @(posedge clk);
      #1 cancel_i = 1'b0;
      check("cancel_done we", 64'(we), 64'd0);
      count_we(3, nwe);
      check("cancel_done no_we", 64'(nwe), 64'd0);
      check("cancel_done hi_hold", 64'(w_hi_o), 64'h0);

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      start_i = 1'b1;
      op_i    = MD_MULT;
      src_a_i = 32'h10;
      src_b_i = 32'h10;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("areset stall", 64'(stall_o), 64'd0);
      check("areset we",    64'(we),      64'd0);
      check("areset hi",    64'(w_hi_o),  64'd0);
      check("areset lo",    64'(w_lo_o),  64'd0);
      @(negedge clk);
      rst = 1'b1;
      count_we(40, nwe);
      check("areset no_we", 64'(nwe), 64'd0);
      run_op("after_reset", MD_MULTU, 32'd6, 32'd7, MUL_LAT, 32'h0, 32'd42, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
